// File: rtl/grid_step_controller.sv
// Tile-grid player movement: turn on a new direction, walk whole tiles while held.
// All state advances on the falling edge of the synchronised VGA vsync.
module grid_step_controller #(
  parameter int TILE_PX     = 16,
  parameter int STEP_PX     = 2,
  parameter int TURN_FRAMES = 4,
  parameter int ANIM_DIV    = 4,
  parameter int MAP_W       = 640,
  parameter int MAP_H       = 480,
  parameter int START_X     = 320,
  parameter int START_Y     = 240
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       VS,
  input  logic [7:0] keycode,
  input  logic       blocked,
  output logic [9:0] Target_X,
  output logic [9:0] Target_Y,
  output logic [9:0] Map_X,
  output logic [9:0] Map_Y,
  output logic [1:0] Direction,
  output logic       Character_Moving,
  output logic [1:0] Anim_Frame
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] TURN = 2'd1;
  localparam logic [1:0] WALK = 2'd2;

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [9:0] TILE      = 10'(TILE_PX);
  localparam logic [9:0] STEP      = 10'(STEP_PX);
  localparam logic [9:0] X_MAX     = 10'(MAP_W - TILE_PX);
  localparam logic [9:0] Y_MAX     = 10'(MAP_H - TILE_PX);
  localparam logic [7:0] TURN_LAST = 8'(TURN_FRAMES - 1);
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

  logic [1:0] state;
  logic [7:0] turn_cnt;
  logic [7:0] anim_cnt;
  logic [9:0] step_acc;
  logic       vs_s1, vs_s2, vs_s3;

  logic       tick;
  logic       key_valid;
  logic [1:0] key_dir;
  logic       edge_block;
  logic       eff_blocked;
  logic [9:0] step_next;

  assign tick             = vs_s3 & ~vs_s2;
  assign step_next        = step_acc + STEP;
  assign Character_Moving = (state == WALK);

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_DOWN;
    case (keycode)
      8'h1A:   key_dir = DIR_UP;
      8'h16:   key_dir = DIR_DOWN;
      8'h04:   key_dir = DIR_LEFT;
      8'h07:   key_dir = DIR_RIGHT;
      default: key_valid = 1'b0;
    endcase
  end

  // Wrapped 10-bit target doubles as the bounds check: underflow lands above the max.
  always_comb begin
    Target_X = Map_X;
    Target_Y = Map_Y;
    case (Direction)
      DIR_DOWN:  Target_Y = Map_Y + TILE;
      DIR_UP:    Target_Y = Map_Y - TILE;
      DIR_LEFT:  Target_X = Map_X - TILE;
      default:   Target_X = Map_X + TILE;
    endcase
    edge_block  = (Target_X > X_MAX) || (Target_Y > Y_MAX);
    eff_blocked = blocked | edge_block;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      turn_cnt   <= 8'd0;
      anim_cnt   <= 8'd0;
      step_acc   <= 10'd0;
      Map_X      <= 10'(START_X);
      Map_Y      <= 10'(START_Y);
      Direction  <= DIR_DOWN;
      Anim_Frame <= 2'd0;
      vs_s1      <= 1'b1;
      vs_s2      <= 1'b1;
      vs_s3      <= 1'b1;
    end else begin
      vs_s1 <= VS;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
      if (tick) begin
        case (state)
          IDLE: begin
            if (key_valid) begin
              if (key_dir != Direction) begin
                Direction <= key_dir;
                turn_cnt  <= TURN_LAST;
                state     <= TURN;
              end else if (!eff_blocked) begin
                step_acc <= 10'd0;
                state    <= WALK;
              end
            end
          end
          TURN: begin
            if (turn_cnt == 8'd0) state <= IDLE;
            else                  turn_cnt <= turn_cnt - 8'd1;
          end
          WALK: begin
            case (Direction)
              DIR_DOWN:  Map_Y <= Map_Y + STEP;
              DIR_UP:    Map_Y <= Map_Y - STEP;
              DIR_LEFT:  Map_X <= Map_X - STEP;
              default:   Map_X <= Map_X + STEP;
            endcase
            if (step_next == TILE) begin
              step_acc   <= 10'd0;
              anim_cnt   <= 8'd0;
              Anim_Frame <= 2'd0;
              state      <= IDLE;
            end else begin
              step_acc <= step_next;
              if (anim_cnt == ANIM_LAST) begin
                anim_cnt   <= 8'd0;
                Anim_Frame <= Anim_Frame + 2'd1;
              end else begin
                anim_cnt <= anim_cnt + 8'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grid_step_controller.sv
// Bench for grid_step_controller: directed scenarios plus a randomized run
// checked against a tick-level behavioural model of the movement rules.
module tb_grid_step_controller;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       VS = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       blocked = 1'b0;
  logic [9:0] Target_X, Target_Y, Map_X, Map_Y;
  logic [1:0] Direction, Anim_Frame;
  logic       Character_Moving;

  int vectors = 0;
  int miscompares = 0;

  // Model: position, facing, ticks of turning left, ticks spent in current walk.
  int m_x, m_y, m_dir, m_turn_left, m_walk_ticks;
  bit m_walk;

  grid_step_controller dut (
    .Clk(Clk), .Reset_n(Reset_n), .VS(VS), .keycode(keycode), .blocked(blocked),
    .Target_X(Target_X), .Target_Y(Target_Y), .Map_X(Map_X), .Map_Y(Map_Y),
    .Direction(Direction), .Character_Moving(Character_Moving), .Anim_Frame(Anim_Frame)
  );

  always #5 Clk = ~Clk;

  function automatic int key_to_dir(input logic [7:0] k);
    case (k)
      8'h16:   return 0;
      8'h1A:   return 1;
      8'h04:   return 2;
      8'h07:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int m_tx();
    return (m_dir == 2) ? m_x - 16 : (m_dir == 3) ? m_x + 16 : m_x;
  endfunction

  function automatic int m_ty();
    return (m_dir == 0) ? m_y + 16 : (m_dir == 1) ? m_y - 16 : m_y;
  endfunction

  function automatic int m_anim();
    return m_walk ? (m_walk_ticks / 4) % 4 : 0;
  endfunction

  task automatic m_reset();
    m_x = 320; m_y = 240; m_dir = 0;
    m_turn_left = 0; m_walk_ticks = 0; m_walk = 0;
  endtask

  task automatic m_tick(input logic [7:0] k, input logic blk);
    int d;
    bit out_of_map;
    if (m_walk) begin
      m_walk_ticks++;
      case (m_dir)
        0: m_y += 2;
        1: m_y -= 2;
        2: m_x -= 2;
        default: m_x += 2;
      endcase
      if (m_walk_ticks * 2 == 16) begin
        m_walk = 0;
        m_walk_ticks = 0;
      end
    end else if (m_turn_left > 0) begin
      m_turn_left--;
    end else begin
      d = key_to_dir(k);
      out_of_map = (m_tx() < 0) || (m_tx() > 624) || (m_ty() < 0) || (m_ty() > 464);
      if (d >= 0) begin
        if (d != m_dir) begin
          m_dir = d;
          m_turn_left = 4;
        end else if (!(blk || out_of_map)) begin
          m_walk = 1;
          m_walk_ticks = 0;
        end
      end
    end
  endtask

  // One full vsync period; the DUT sees exactly one falling edge.
  task automatic do_tick();
    VS = 1'b0;
    repeat (6) @(negedge Clk);
    VS = 1'b1;
    repeat (6) @(negedge Clk);
    m_tick(keycode, blocked);
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    VS = 1'b1;
    repeat (2) @(negedge Clk);
    m_reset();
    vectors += 5;
    if (Map_X !== 10'd320) begin miscompares++; $display("FAIL reset_map_x: got %0d expected 320", Map_X); end
    if (Map_Y !== 10'd240) begin miscompares++; $display("FAIL reset_map_y: got %0d expected 240", Map_Y); end
    if (Direction !== 2'd0) begin miscompares++; $display("FAIL reset_dir: got %0d expected 0", Direction); end
    if (Character_Moving !== 1'b0) begin miscompares++; $display("FAIL reset_moving: got %0d expected 0", Character_Moving); end
    if (Anim_Frame !== 2'd0) begin miscompares++; $display("FAIL reset_anim: got %0d expected 0", Anim_Frame); end
    Reset_n = 1'b1;
    keycode = 8'h07;
    repeat (30) @(negedge Clk);
    vectors += 3;
    if (Map_X !== 10'd320) begin miscompares++; $display("FAIL no_tick_map_x: got %0d expected 320", Map_X); end
    if (Direction !== 2'd0) begin miscompares++; $display("FAIL no_tick_dir: got %0d expected 0", Direction); end
    if (Character_Moving !== 1'b0) begin miscompares++; $display("FAIL no_tick_moving: got %0d expected 0", Character_Moving); end
    keycode = 8'h00;
  endtask

  task automatic test_turn_walk();
    int ex, ea;
    bit em;
    apply_reset();
    keycode = 8'h07;
    blocked = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      do_tick();
      ex = (k <= 6) ? 320 : 320 + 2 * (k - 6);
      em = (k >= 6 && k < 14);
      ea = em ? ((k - 6) / 4) % 4 : 0;
      vectors += 4;
      if (Direction !== 2'd3) begin miscompares++; $display("FAIL turn_walk_dir tick %0d: got %0d expected 3", k, Direction); end
      if (Map_X !== 10'(ex)) begin miscompares++; $display("FAIL turn_walk_x tick %0d: got %0d expected %0d", k, Map_X, ex); end
      if (Character_Moving !== em) begin miscompares++; $display("FAIL turn_walk_moving tick %0d: got %0d expected %0d", k, Character_Moving, em); end
      if (Anim_Frame !== 2'(ea)) begin miscompares++; $display("FAIL turn_walk_anim tick %0d: got %0d expected %0d", k, Anim_Frame, ea); end
    end
    keycode = 8'h00;
    do_tick();
  endtask

  task automatic test_blocked();
    keycode = 8'h16;
    blocked = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      do_tick();
      vectors += 2;
      if (Map_Y !== 10'd240) begin miscompares++; $display("FAIL blocked_y tick %0d: got %0d expected 240", k, Map_Y); end
      if (Character_Moving !== 1'b0) begin miscompares++; $display("FAIL blocked_moving tick %0d: got %0d expected 0", k, Character_Moving); end
    end
    vectors++;
    if (Direction !== 2'd0) begin miscompares++; $display("FAIL blocked_dir: got %0d expected 0", Direction); end
    keycode = 8'h00;
    blocked = 1'b0;
  endtask

  task automatic test_step_completion();
    apply_reset();
    keycode = 8'h07;
    blocked = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 10) begin
        keycode = 8'h00;
        blocked = 1'b1;
      end
      do_tick();
      vectors++;
      if (Map_X !== 10'((k <= 6) ? 320 : 320 + 2 * (k - 6))) begin
        miscompares++;
        $display("FAIL step_complete_x tick %0d: got %0d expected %0d", k, Map_X, (k <= 6) ? 320 : 320 + 2 * (k - 6));
      end
    end
    do_tick();
    vectors += 2;
    if (Map_X !== 10'd336) begin miscompares++; $display("FAIL step_complete_final_x: got %0d expected 336", Map_X); end
    if (Character_Moving !== 1'b0) begin miscompares++; $display("FAIL step_complete_idle: got %0d expected 0", Character_Moving); end
    blocked = 1'b0;
  endtask

  task automatic test_map_edge();
    int n = 0;
    apply_reset();
    keycode = 8'h04;
    blocked = 1'b0;
    while (!(m_x == 0 && !m_walk && m_turn_left == 0) && n < 400) begin
      do_tick();
      n++;
      vectors++;
      if (Map_X !== 10'(m_x)) begin miscompares++; $display("FAIL edge_walk_x tick %0d: got %0d expected %0d", n, Map_X, m_x); end
    end
    vectors++;
    if (n >= 400) begin miscompares++; $display("FAIL edge_reach: got %0d ticks expected under 400", n); end
    for (int k = 0; k < 10; k++) begin
      do_tick();
      vectors += 3;
      if (Map_X !== 10'd0) begin miscompares++; $display("FAIL edge_hold_x: got %0d expected 0", Map_X); end
      if (Target_X !== 10'd1008) begin miscompares++; $display("FAIL edge_target_x: got %0d expected 1008", Target_X); end
      if (Character_Moving !== 1'b0) begin miscompares++; $display("FAIL edge_moving: got %0d expected 0", Character_Moving); end
    end
    keycode = 8'h00;
  endtask

  task automatic test_reset_mid_walk();
    apply_reset();
    keycode = 8'h07;
    for (int k = 1; k <= 9; k++) do_tick();
    vectors += 2;
    if (Map_X !== 10'd326) begin miscompares++; $display("FAIL mid_walk_x: got %0d expected 326", Map_X); end
    if (Character_Moving !== 1'b1) begin miscompares++; $display("FAIL mid_walk_moving: got %0d expected 1", Character_Moving); end
    apply_reset();
    vectors += 3;
    if (Map_X !== 10'd320) begin miscompares++; $display("FAIL mid_reset_x: got %0d expected 320", Map_X); end
    if (Character_Moving !== 1'b0) begin miscompares++; $display("FAIL mid_reset_moving: got %0d expected 0", Character_Moving); end
    if (Direction !== 2'd0) begin miscompares++; $display("FAIL mid_reset_dir: got %0d expected 0", Direction); end
    for (int k = 0; k < 4; k++) begin
      keycode = (k % 2 == 0) ? 8'h00 : 8'h2C;
      do_tick();
      vectors += 3;
      if (Map_X !== 10'd320 || Map_Y !== 10'd240) begin miscompares++; $display("FAIL nokey_pos: got %0d,%0d expected 320,240", Map_X, Map_Y); end
      if (Direction !== 2'd0) begin miscompares++; $display("FAIL nokey_dir: got %0d expected 0", Direction); end
      if (Character_Moving !== 1'b0) begin miscompares++; $display("FAIL nokey_moving: got %0d expected 0", Character_Moving); end
    end
  endtask

  task automatic test_random();
    logic [7:0] keys [6] = '{8'h16, 8'h1A, 8'h04, 8'h07, 8'h00, 8'h2C};
    int sel;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 99) == 0) apply_reset();
      sel = $urandom_range(0, 8);
      if (sel < 6) keycode = keys[sel];
      else if (sel == 6) keycode = 8'($urandom);
      blocked = ($urandom_range(0, 3) == 0);
      do_tick();
      vectors += 7;
      if (Map_X !== 10'(m_x)) begin miscompares++; $display("FAIL rand_x t%0d: got %0d expected %0d", t, Map_X, m_x); end
      if (Map_Y !== 10'(m_y)) begin miscompares++; $display("FAIL rand_y t%0d: got %0d expected %0d", t, Map_Y, m_y); end
      if (Direction !== 2'(m_dir)) begin miscompares++; $display("FAIL rand_dir t%0d: got %0d expected %0d", t, Direction, m_dir); end
      if (Character_Moving !== m_walk) begin miscompares++; $display("FAIL rand_moving t%0d: got %0d expected %0d", t, Character_Moving, m_walk); end
      if (Anim_Frame !== 2'(m_anim())) begin miscompares++; $display("FAIL rand_anim t%0d: got %0d expected %0d", t, Anim_Frame, m_anim()); end
      if (Target_X !== 10'(m_tx())) begin miscompares++; $display("FAIL rand_tx t%0d: got %0d expected %0d", t, Target_X, 10'(m_tx())); end
      if (Target_Y !== 10'(m_ty())) begin miscompares++; $display("FAIL rand_ty t%0d: got %0d expected %0d", t, Target_Y, 10'(m_ty())); end
    end
  endtask

  initial begin
    test_reset();
    test_turn_walk();
    test_blocked();
    test_step_completion();
    test_map_edge();
    test_reset_mid_walk();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/grid_step_controller.md
Name: grid_step_controller

Overview:
- Tile-grid player movement stage. Consumes the USB keycode from the SoC and the VGA vertical sync.
- Produces the player map position, facing direction, moving flag and walk-animation frame for the color mapper's player and map-scroll logic.
- Movement is Pokemon-style: a press in a new direction first turns the player; holding it walks whole tiles; a step, once started, always completes.

Parameters:
- TILE_PX, 16, tile size in pixels (power of 2).
- STEP_PX, 2, pixels moved per frame tick; must divide TILE_PX.
- TURN_FRAMES, 4, frame ticks spent turning before a walk may start.
- ANIM_DIV, 4, frame ticks per animation frame advance.
- MAP_W, 640, map width in pixels (multiple of TILE_PX).
- MAP_H, 480, map height in pixels (multiple of TILE_PX).
- START_X, 320, reset X position (multiple of TILE_PX).
- START_Y, 240, reset Y position (multiple of TILE_PX).

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- VS  in  1  raw VGA vsync (active low); synchronised internally.
- keycode  in  8  USB HID keycode; 0x1A=W/up, 0x16=S/down, 0x04=A/left, 0x07=D/right; any other value = no key.
- blocked  in  1  collision lookup result for Target_X/Target_Y; combinational from an external map ROM.
- Target_X  out  10  X of the tile in front of the player.
- Target_Y  out  10  Y of the tile in front of the player.
- Map_X  out  10  player X in pixels.
- Map_Y  out  10  player Y in pixels.
- Direction  out  2  facing: 0=down, 1=up, 2=left, 3=right.
- Character_Moving  out  1  high while in WALK.
- Anim_Frame  out  2  walk-cycle frame index.

Behaviour:
- Frame tick: VS passes through a 2-flop synchroniser, then a third flop. tick = prev 1 and current 0 (falling edge), one Clk wide. All state changes below happen only on tick cycles.
- Reset (Reset_n=0 at a Clk edge) sets:
  - Map_X=START_X, Map_Y=START_Y.
  - Direction=0, Character_Moving=0, Anim_Frame=0.
  - State IDLE, all counters 0, synchroniser flops 1.
- Reset takes priority over everything, including a walk in progress.
- Target is combinational from registered state: Map position offset by TILE_PX in Direction (Y+ for down, Y- for up, X- for left, X+ for right).
- Edge rule: a target outside 0..MAP_W-TILE_PX or 0..MAP_H-TILE_PX is treated as blocked regardless of the blocked input. Target_X/Y still output the wrapped 10-bit value.
- States:
  - IDLE, on tick, with key decoded to direction d:
    - No key: stay.
    - d != Direction: Direction<=d, turn_cnt<=TURN_FRAMES-1, go TURN.
    - d == Direction and effectively blocked: stay; nothing changes.
    - d == Direction and not blocked: go WALK with step_acc=0. No position change on this tick.
  - TURN, on tick:
    - turn_cnt==0: go IDLE.
    - Otherwise decrement turn_cnt.
    - Key changes are ignored in TURN.
  - WALK, on tick:
    - Position += STEP_PX in Direction; step_acc += STEP_PX.
    - When the updated step_acc == TILE_PX: go IDLE, step_acc=0. Position is then tile-aligned.
    - Keycode and blocked are ignored mid-step; a release never truncates a step.
- A held key chains steps, costing one IDLE tick between tiles.
- Character_Moving is 1 exactly while the state is WALK (registered, follows the state).
- Anim_Frame:
  - In WALK, anim_cnt increments each tick. On reaching ANIM_DIV-1 it wraps to 0 and Anim_Frame increments mod 4.
  - On leaving WALK, Anim_Frame and anim_cnt clear to 0.
- Widths: all position arithmetic is 10-bit unsigned. The bounds check prevents underflow or overflow of committed positions.
- VS held constant gives no ticks, so no state change.

Test Plan:
- Reset: drive Reset_n=0 for 2 cycles -> Map_X=320, Map_Y=240, Direction=0, Character_Moving=0, Anim_Frame=0. Reset_n high but VS stuck at 1 -> outputs unchanged.
- Turn then walk: hold keycode 0x07 with blocked=0.
  - Tick 1: Direction=3.
  - Ticks 2-5: TURN.
  - Tick 6: enter WALK.
  - Ticks 7-14: Map_X rises by 2 per tick.
  - Result: Map_X=336 after tick 14; Character_Moving falls on tick 14; Anim_Frame advances 0->1 after 4 WALK ticks.
- Blocked: facing down, keycode 0x16, blocked=1 for 20 ticks -> Map_Y=240 throughout, Character_Moving=0.
- Step completion: start a walk right, set keycode=0x00 after 3 WALK ticks -> Map_X still reaches 336, then IDLE.
- Map edge: START_X=0, facing left, hold 0x04 with blocked=0 -> Target_X=1008 (wrapped), no movement, Map_X=0.
- Reset mid-walk: Reset_n=0 for one cycle at Map_X=326 -> next edge Map_X=320, state IDLE, Character_Moving=0. Keycodes 0x00 and 0x2C cause no state change.
